fetch_pc_controller: RTL and testbench

- Owns the program counter and sequences instruction fetch over a single-outstanding req/ack instruction-memory port.
- Applies redirects from the execute stage: a taken branch (the branch comparator's branch_ctrl) or a jump.
- Presents one fetched instruction at a time to decode with a valid/stall hold, and pulses flush when a redirect occurs.
- Sits between instruction memory and the decode stage of the core.

---
 rtl/fetch_pc_controller.sv | 130 +++++++++++++
 tb/tb_fetch_pc_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_controller.sv
// rtl/fetch_pc_controller.sv - program counter and single-outstanding instruction fetch sequencer
module fetch_pc_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        branch_ctrl,
    input  logic        jump,
    input  logic [31:0] target_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        flush
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2,
        VALID   = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] target_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        flush_q;

    logic        redirect_d;
    logic [31:0] target_d;
    logic [31:0] pc_inc_d;
    logic [31:0] discard_pc_d;

    assign redirect_d   = ex_valid & (branch_ctrl | jump);
    assign target_d     = target_pc & 32'hFFFF_FFFC;
    assign pc_inc_d     = pc_q + 32'd4;
    // A redirect landing on the closing ack of a discarded fetch is the newest target.
    assign discard_pc_d = redirect_d ? target_d : target_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            target_q     <= RESET_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            flush_q      <= 1'b0;
        end else begin
            flush_q <= redirect_d;
            case (state_q)
                BOOT: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                    if (redirect_d) begin
                        pc_q        <= target_d;
                        imem_addr_q <= target_d;
                    end else begin
                        imem_addr_q <= pc_q;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        if (redirect_d) begin
                            pc_q        <= target_d;
                            imem_addr_q <= target_d;
                        end else begin
                            inst_q       <= imem_rdata;
                            inst_pc_q    <= pc_q;
                            inst_valid_q <= 1'b1;
                            pc_q         <= pc_inc_d;
                            imem_req_q   <= 1'b0;
                            state_q      <= VALID;
                        end
                    end else if (redirect_d) begin
                        // The memory still owes a response; keep the address stable and drop it later.
                        target_q <= target_d;
                        state_q  <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        pc_q        <= discard_pc_d;
                        imem_addr_q <= discard_pc_d;
                        state_q     <= REQ;
                    end else if (redirect_d) begin
                        target_q <= target_d;
                    end
                end
                VALID: begin
                    if (redirect_d) begin
                        inst_valid_q <= 1'b0;
                        pc_q         <= target_d;
                        imem_addr_q  <= target_d;
                        imem_req_q   <= 1'b1;
                        state_q      <= REQ;
                    end else if (!stall) begin
                        inst_valid_q <= 1'b0;
                        imem_addr_q  <= pc_q;
                        imem_req_q   <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign flush      = flush_q;

endmodule

// File: tb/tb_fetch_pc_controller.sv
// tb/tb_fetch_pc_controller.sv - randomized scoreboard bench for fetch_pc_controller
module tb_fetch_pc_controller;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        branch_ctrl = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] target_pc = 32'h0;
    logic        stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        flush;

    always #5 clk = ~clk;

    fetch_pc_controller #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .branch_ctrl(branch_ctrl),
        .jump       (jump),
        .target_pc  (target_pc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .flush      (flush)
    );

    typedef struct {
        bit          rst;
        bit          redir;
        bit          stall;
        bit          ack;
        logic [31:0] next_pc;
    } rec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    rec_t  cyc_q[$];
    inst_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;

    // Architectural model: where the next fetch must go and which fetches survive.
    logic [31:0] m_next_pc  = RESET_PC;
    logic [31:0] m_cur_addr = RESET_PC;
    bit          m_doomed   = 1'b1;
    bit          prev_req   = 1'b0;
    bit          prev_ack   = 1'b0;
    int          wait_left  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC | (t & 32'h3);
        return t & 32'h0000_0FFF;
    endfunction

    // am: 0 = random-latency memory, 1 = withhold ack, 2 = ack now if requested
    task automatic step(input bit r, input bit exv, input bit br, input bit jp,
                        input logic [31:0] tgt, input bit stl, input int am);
        bit   req_now;
        bit   start;
        bit   ack;
        bit   redir;
        rec_t rc;
        req_now = (imem_req === 1'b1);
        start   = req_now && (!prev_req || prev_ack);
        if (start) begin
            m_cur_addr = m_next_pc;
            m_doomed   = 1'b0;
            wait_left  = $urandom_range(0, 3);
        end
        if (r) ack = 1'b0;
        else if (req_now) ack = (am == 2) || (am == 0 && wait_left == 0);
        else ack = (am == 0) && ($urandom_range(0, 7) == 0);
        if (req_now && !ack && wait_left > 0) wait_left--;
        redir = exv && (br || jp);

        rst         = r;
        ex_valid    = exv;
        branch_ctrl = br;
        jump        = jp;
        target_pc   = tgt;
        stall       = stl;
        imem_ack    = ack;
        imem_rdata  = req_now ? mem_word(imem_addr) : $urandom;

        if (r) begin
            m_next_pc = RESET_PC;
            m_doomed  = 1'b1;
            exp_q.delete();
        end else begin
            if (req_now && redir) m_doomed = 1'b1;
            if (redir) m_next_pc = {tgt[31:2], 2'b00};
            if (req_now && ack && !m_doomed) begin
                exp_q.push_back('{m_cur_addr, mem_word(m_cur_addr)});
                m_next_pc = m_cur_addr + 32'd4;
            end
        end
        rc.rst     = r;
        rc.redir   = redir;
        rc.stall   = stl;
        rc.ack     = ack && req_now;
        rc.next_pc = m_next_pc;
        cyc_q.push_back(rc);
        prev_req = req_now && !r;
        prev_ack = ack && req_now;
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit stl, input int am, input bit br);
        repeat (n) step(1'b0, 1'b0, br, 1'b0, 32'h0, stl, am);
    endtask

    task automatic wait_valid(input bit stl);
        int k;
        k = 0;
        while (inst_valid !== 1'b1 && k < 40) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, stl, 0);
            k++;
        end
        chk("wait_valid", inst_valid, 1'b1);
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 40) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
            k++;
        end
        chk("wait_req", imem_req, 1'b1);
    endtask

    initial begin : monitor
        rec_t        rc;
        inst_t       ei;
        logic        p_req;
        logic        p_valid;
        logic [31:0] p_addr;
        logic [31:0] p_inst;
        logic [31:0] p_pc;
        bit          st;
        p_req   = 1'b0;
        p_valid = 1'b0;
        p_addr  = 32'h0;
        p_inst  = 32'h0;
        p_pc    = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() != 0) begin
                rc = cyc_q.pop_front();
                if (rc.rst) begin
                    chk("rst_req", imem_req, 1'b0);
                    chk("rst_addr", imem_addr, RESET_PC);
                    chk("rst_valid", inst_valid, 1'b0);
                    chk("rst_inst", inst, 32'h0);
                    chk("rst_inst_pc", inst_pc, 32'h0);
                    chk("rst_flush", flush, 1'b0);
                end else begin
                    chk("flush", flush, rc.redir);
                    chk("addr_align", imem_addr[1:0], 2'b00);
                    if (p_req && !rc.ack) begin
                        chk("req_held", imem_req, 1'b1);
                        chk("addr_stable", imem_addr, p_addr);
                    end
                    st = (imem_req === 1'b1) && (!p_req || rc.ack);
                    if (st) chk("req_addr", imem_addr, rc.next_pc);
                    if (inst_valid === 1'b1) chk("req_while_valid", imem_req, 1'b0);
                    if (p_valid) begin
                        chk("valid_hold", inst_valid, rc.stall && !rc.redir);
                        if (inst_valid === 1'b1) begin
                            chk("inst_hold", inst, p_inst);
                            chk("inst_pc_hold", inst_pc, p_pc);
                        end
                    end else if (inst_valid === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_valid", inst_valid, 1'b0);
                        end else begin
                            ei = exp_q.pop_front();
                            chk("inst_pc", inst_pc, ei.pc);
                            chk("inst", inst, ei.data);
                        end
                    end
                end
                p_req   = imem_req;
                p_valid = inst_valid;
                p_addr  = imem_addr;
                p_inst  = inst;
                p_pc    = inst_pc;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);

        // First fetch from reset, ack two cycles into the request
        run(3, 1'b0, 1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2);
        run(4, 1'b0, 1, 1'b0);
        run(6, 1'b0, 0, 1'b0);

        // Decode stall held for five cycles
        wait_valid(1'b1);
        run(5, 1'b1, 0, 1'b0);
        run(6, 1'b0, 0, 1'b0);

        // Branch redirect while an instruction is presented
        wait_valid(1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0103, 1'b1, 0);
        run(8, 1'b0, 0, 1'b0);

        // Two redirects against one pending request, ack three cycles later
        wait_req();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2);
        run(8, 1'b0, 0, 1'b0);

        // Redirect coincident with ack
        wait_req();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 2);
        run(8, 1'b0, 0, 1'b0);

        // branch_ctrl without ex_valid must be ignored
        run(12, 1'b0, 0, 1'b1);

        // Wrap from the top word of the address space
        wait_valid(1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 0);
        run(14, 1'b0, 0, 1'b0);

        // Reset while discarding
        wait_req();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 1'b0, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        run(10, 1'b0, 0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                 rand_tgt(), $urandom_range(0, 2) == 0, 0);
        end

        run(20, 1'b0, 0, 1'b0);
        run(2, 1'b1, 1, 1'b0);
        @(posedge clk);
        #2;
        chk("drain_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
